// File: rtl/rv32i_lsu_pkg.sv
// rv32i_lsu_pkg: shared funct3 codes, FSM states, error codes and lane helpers for the load/store unit
package rv32i_lsu_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_FUNCT3   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;
  // funct3[1:0] encodes access size for both loads and stores
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'd0) ? 4'b0001 << off :
           (f3[1:0] == 2'd1) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/rv32i_load_align.sv
// rv32i_load_align: extracts the addressed byte/half from a load word and sign/zero extends it
module rv32i_load_align
  import rv32i_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);
  logic [31:0] w_shift;
  logic        w_sext;
  assign w_shift = i_rdata >> {i_off, 3'b000};
  assign w_sext  = ~i_funct3[2];
  always_comb begin
    o_data = (i_funct3[1:0] == 2'd0) ? {{24{w_sext & w_shift[7]}}, w_shift[7:0]} :
             (i_funct3[1:0] == 2'd1) ? {{16{w_sext & w_shift[15]}}, w_shift[15:0]} : i_rdata;
  end
endmodule

// File: rtl/rv32i_load_store_unit.sv
// rv32i_load_store_unit: multi-cycle RV32I load/store unit on a req/gnt/rvalid bus with aligned writeback
module rv32i_load_store_unit
  import rv32i_lsu_pkg::*;
#(
  parameter int NUM_OF_SETS    = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int RDW = $clog2(NUM_OF_SETS),
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_is_store,
  input  logic [2:0]                i_req_funct3,
  input  logic [DATA_BUS_WIDTH-1:0] i_req_addr,
  input  logic [DATA_BUS_WIDTH-1:0] i_req_wdata,
  input  logic [RDW-1:0]            i_req_rd,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [DATA_BUS_WIDTH-1:0] o_mem_addr,
  output logic [3:0]                o_mem_be,
  output logic [DATA_BUS_WIDTH-1:0] o_mem_wdata,
  input  logic                      i_mem_gnt,
  input  logic                      i_mem_rvalid,
  input  logic [DATA_BUS_WIDTH-1:0] i_mem_rdata,
  output logic                      o_wb_en,
  output logic [RDW-1:0]            o_wb_addr,
  output logic [DATA_BUS_WIDTH-1:0] o_wb_data,
  output logic                      o_err_valid,
  output logic [1:0]                o_err_code
);
  state_t                    r_state, w_next;
  logic                      r_is_store;
  logic [2:0]                r_funct3;
  logic [1:0]                r_off;
  logic [RDW-1:0]            r_rd;
  logic [TW-1:0]             r_timer;
  logic [TW-1:0]             w_timer_inc;
  logic                      w_legal, w_misalign, w_start, w_timeout;
  logic [DATA_BUS_WIDTH-1:0] w_load_data, w_store_data;
  assign o_req_ready = (r_state == S_IDLE);
  assign w_legal     = i_req_is_store ? (i_req_funct3 < 3'd3)
                                      : (i_req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign w_misalign  = ((i_req_funct3[1:0] == 2'd1) & i_req_addr[0]) |
                       ((i_req_funct3[1:0] == 2'd2) & (|i_req_addr[1:0]));
  assign w_start     = o_req_ready & i_req_valid & w_legal & ~w_misalign;
  assign w_timer_inc = r_timer + 1'b1;
  // a response arriving on the final cycle still beats the timeout
  assign w_timeout   = (r_state == S_WAIT) & ~i_mem_rvalid & (w_timer_inc == TW'(TIMEOUT_CYCLES));
  assign w_store_data = (i_req_funct3[1:0] == 2'd0) ? {4{i_req_wdata[7:0]}} :
                        (i_req_funct3[1:0] == 2'd1) ? {2{i_req_wdata[15:0]}} : i_req_wdata;
  rv32i_load_align u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_off),
    .i_rdata  (i_mem_rdata),
    .o_data   (w_load_data)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_REQ : S_IDLE;
      S_REQ:   w_next = i_mem_gnt ? S_WAIT : S_REQ;
      S_WAIT:  w_next = i_mem_rvalid ? (r_is_store ? S_IDLE : S_WB) : (w_timeout ? S_IDLE : S_WAIT);
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
      o_wb_en     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
      o_err_valid <= 1'b0;
      o_err_code  <= ERR_NONE;
      r_is_store  <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_rd        <= '0;
      r_timer     <= '0;
    end else begin
      o_wb_en     <= 1'b0;
      o_err_valid <= 1'b0;
      if (o_req_ready && i_req_valid) begin
        if (!w_legal) begin
          o_err_valid <= 1'b1;
          o_err_code  <= ERR_FUNCT3;
        end else if (w_misalign) begin
          o_err_valid <= 1'b1;
          o_err_code  <= ERR_MISALIGN;
        end else begin
          o_mem_req   <= 1'b1;
          o_mem_we    <= i_req_is_store;
          o_mem_addr  <= {i_req_addr[DATA_BUS_WIDTH-1:2], 2'b00};
          o_mem_be    <= byte_en(i_req_funct3, i_req_addr[1:0]);
          o_mem_wdata <= w_store_data;
          r_is_store  <= i_req_is_store;
          r_funct3    <= i_req_funct3;
          r_off       <= i_req_addr[1:0];
          r_rd        <= i_req_rd;
        end
      end
      if (r_state == S_REQ && i_mem_gnt) begin
        o_mem_req <= 1'b0;
        o_mem_we  <= 1'b0;
        r_timer   <= '0;
      end
      if (r_state == S_WAIT) begin
        r_timer <= w_timer_inc;
        if (i_mem_rvalid && !r_is_store) begin
          o_wb_en   <= |r_rd;
          o_wb_addr <= r_rd;
          o_wb_data <= w_load_data;
        end else if (w_timeout) begin
          o_err_valid <= 1'b1;
          o_err_code  <= ERR_TIMEOUT;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// tb_rv32i_load_store_unit: directed-vector bench for the load/store unit (timeout shortened to 8)
module tb_rv32i_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic        req_ready, mem_req, mem_we, wb_en, err_valid;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;
  logic [4:0]  wb_addr;
  logic [1:0]  err_code;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  rv32i_load_store_unit #(.NUM_OF_SETS(32), .DATA_BUS_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_is_store(req_is_store),
    .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_rd(req_rd),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_wb_en(wb_en), .o_wb_addr(wb_addr), .o_wb_data(wb_data),
    .o_err_valid(err_valid), .o_err_code(err_code)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask
  task automatic check_idle_outputs(input string t);
    chk({t, "_ready"}, req_ready, 1);
    chk({t, "_req"}, mem_req, 0);
    chk({t, "_we"}, mem_we, 0);
    chk({t, "_addr"}, mem_addr, 0);
    chk({t, "_be"}, mem_be, 0);
    chk({t, "_wdata"}, mem_wdata, 0);
    chk({t, "_wben"}, wb_en, 0);
    chk({t, "_wbaddr"}, wb_addr, 0);
    chk({t, "_wbdata"}, wb_data, 0);
    chk({t, "_errv"}, err_valid, 0);
    chk({t, "_errc"}, err_code, 0);
  endtask
  task automatic do_load(input string t, input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0, rd);
    chk({t, "_req"}, mem_req, 1);
    chk({t, "_we"}, mem_we, 0);
    chk({t, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({t, "_be"}, mem_be, be);
    chk({t, "_busy"}, req_ready, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({t, "_reqdrop"}, mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
    chk({t, "_wben"}, wb_en, rd != 0);
    if (rd != 0) begin
      chk({t, "_wbaddr"}, wb_addr, rd);
      chk({t, "_wbdata"}, wb_data, exp);
    end
    chk({t, "_wbready"}, req_ready, 0);
    tick();
    chk({t, "_wbpulse"}, wb_en, 0);
    chk({t, "_ready"}, req_ready, 1);
  endtask
  task automatic bad_req(input string t, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [1:0] code);
    issue(st, f3, a, 32'h0, 5'd1);
    chk({t, "_errv"}, err_valid, 1);
    chk({t, "_errc"}, err_code, code);
    chk({t, "_noreq"}, mem_req, 0);
    chk({t, "_ready"}, req_ready, 1);
    tick();
    chk({t, "_errpulse"}, err_valid, 0);
    chk({t, "_noreq2"}, mem_req, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic seen_wb;
    #12;
    check_idle_outputs("rst");
    tick();
    rst_n = 1'b1;
    tick();
    do_load("lw",  3'd2, 32'h100, 5'd5, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    do_load("lb",  3'd0, 32'h103, 5'd6, 32'h80112233, 4'h8, 32'hFFFFFF80);
    do_load("lbu", 3'd4, 32'h103, 5'd7, 32'h80112233, 4'h8, 32'h00000080);
    do_load("lhu", 3'd5, 32'h102, 5'd8, 32'h80112233, 4'hC, 32'h00008011);
    do_load("lh",  3'd1, 32'h100, 5'd9, 32'h1234F00D, 4'h3, 32'hFFFFF00D);
    do_load("rd0", 3'd2, 32'h104, 5'd0, 32'h55555555, 4'hF, 32'h0);
    // store with grant withheld for three cycles
    issue(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk("sh_req", mem_req, 1);
      chk("sh_we", mem_we, 1);
      chk("sh_addr", mem_addr, 32'h200);
      chk("sh_be", mem_be, 4'hC);
      chk("sh_wdata", mem_wdata, 32'hABCDABCD);
      if (i == 3) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    chk("sh_reqdrop", mem_req, 0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("sh_nowb", wb_en, 0);
    chk("sh_ready", req_ready, 1);
    bad_req("mis_lw", 1'b0, 3'd2, 32'h101, 2'd1);
    bad_req("mis_lh", 1'b0, 3'd1, 32'h103, 2'd1);
    bad_req("f3_ld3", 1'b0, 3'd3, 32'h100, 2'd2);
    bad_req("f3_st4", 1'b1, 3'd4, 32'h100, 2'd2);
    // timeout: no response for 8 WAIT cycles
    issue(1'b0, 3'd2, 32'h300, 32'h0, 5'd3);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    n = 0; seen_wb = 1'b0;
    while (!err_valid && n < 20) begin
      tick();
      n++;
      seen_wb |= wb_en;
    end
    chk("to_cycles", n, 8);
    chk("to_errc", err_code, 2'd3);
    chk("to_nowb", seen_wb, 0);
    chk("to_ready", req_ready, 1);
    tick();
    chk("to_errpulse", err_valid, 0);
    // reset in WAIT, then a late response must be ignored
    issue(1'b0, 3'd2, 32'h400, 32'h0, 5'd4);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("late_nowb", wb_en, 0);
    chk("late_ready", req_ready, 1);
    do_load("post", 3'd2, 32'h500, 5'd10, 32'h0BADF00D, 4'hF, 32'h0BADF00D);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
